// File: rtl/md_unit_if.sv
// ---------------------------------------------------------------------------
// md_unit_if : bundle of the request/result signals between the pipeline
// core and the multiply/divide unit.
//
//   start       core -> unit  request a MULT/MULTU/DIV/DIVU this cycle
//   op          core -> unit  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   rs_data     core -> unit  operand A (multiplicand / dividend / MTxx data)
//   rt_data     core -> unit  operand B (multiplier / divisor)
//   hi_we       core -> unit  MTHI: load rs_data into HI
//   lo_we       core -> unit  MTLO: load rs_data into LO
//   busy        unit -> core  operation in progress
//   done        unit -> core  one-cycle pulse when HI/LO hold a new result
//   div_by_zero unit -> core  one-cycle pulse with done for a zero divisor
//   hi, lo      unit -> core  HI/LO registers for MFHI/MFLO
//
// The master modport is the core side; the slave modport is the unit side.
// ---------------------------------------------------------------------------
interface md_unit_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic        hi_we;
   logic        lo_we;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, rs_data, rt_data, hi_we, lo_we,
      input  busy, done, div_by_zero, hi, lo
   );

   modport slave (
      input  start, op, rs_data, rt_data, hi_we, lo_we,
      output busy, done, div_by_zero, hi, lo
   );
endinterface

// File: rtl/md_unit.sv
// ---------------------------------------------------------------------------
// md_unit : iterative 32-bit multiply/divide unit with HI/LO registers.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    md_unit_if.slave (start/op/operands/MTHI/MTLO in,
//          busy/done/div_by_zero/HI/LO out)
//
// One start runs 33 cycles: 32 radix-2 iterations (shift-add multiply or
// restoring divide on operand magnitudes) followed by one sign-fix cycle
// that writes HI/LO and pulses done.
// ---------------------------------------------------------------------------
module md_unit (
   input  logic      clk,
   input  logic      reset,
   md_unit_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t      state, state_next;
   logic [4:0]  count;
   logic [1:0]  op_q;
   logic [31:0] a_q, b_q;
   logic        sign_a, sign_b, b_zero;
   logic [63:0] acc;
   logic [31:0] hi_q, lo_q;
   logic        done_q, dbz_q;

   logic        latch_en, calc_en, fix_en, mthi_en, mtlo_en, busy;

   // Operand capture: op[0]=0 marks the signed variants (MULT, DIV), whose
   // operands are reduced to magnitude plus sign flag.
   logic        signed_op, neg_rs, neg_rt;
   logic [31:0] rs_mag, rt_mag;

   assign signed_op = ~bus.op[0];
   assign neg_rs    = signed_op & bus.rs_data[31];
   assign neg_rt    = signed_op & bus.rt_data[31];
   assign rs_mag    = neg_rs ? -bus.rs_data : bus.rs_data;
   assign rt_mag    = neg_rt ? -bus.rt_data : bus.rt_data;

   // One iteration step. acc holds {upper, multiplier} for multiply and
   // {partial remainder, dividend/quotient} for divide. The remainder stays
   // below the divisor, so only the shifted-in value needs a 33rd bit.
   logic [32:0] mul_sum, div_shift;
   logic [31:0] div_diff;
   logic [63:0] acc_step;

   always_comb begin
      mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_q} : 33'd0);
      div_shift = {acc[63:32], acc[31]};
      div_diff  = div_shift[31:0] - b_q;
      if (op_q[1]) begin
         if (div_shift >= {1'b0, b_q})
            acc_step = {div_diff, acc[30:0], 1'b1};
         else
            acc_step = {div_shift[31:0], acc[30:0], 1'b0};
      end else begin
         acc_step = {mul_sum, acc[31:1]};
      end
   end

   // Sign correction applied on the FIX edge. A zero divisor forces an
   // all-ones quotient; the remainder naturally ends up equal to the
   // dividend once its sign is restored.
   logic        negate;
   logic [63:0] prod_fix;
   logic [31:0] quot_fix, rem_fix, hi_res, lo_res;

   always_comb begin
      negate   = sign_a ^ sign_b;
      prod_fix = negate ? -acc : acc;
      quot_fix = b_zero ? 32'hFFFF_FFFF : (negate ? -acc[31:0] : acc[31:0]);
      rem_fix  = sign_a ? -acc[63:32] : acc[63:32];
      hi_res   = op_q[1] ? rem_fix  : prod_fix[63:32];
      lo_res   = op_q[1] ? quot_fix : prod_fix[31:0];
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state and control strobes. MTHI/MTLO are honoured only in IDLE
   // and only when no start arrives in the same cycle.
   always_comb begin
      state_next = state;
      latch_en   = 1'b0;
      calc_en    = 1'b0;
      fix_en     = 1'b0;
      mthi_en    = 1'b0;
      mtlo_en    = 1'b0;
      busy       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               latch_en   = 1'b1;
               state_next = CALC;
            end else begin
               mthi_en = bus.hi_we;
               mtlo_en = bus.lo_we;
            end
         end
         CALC: begin
            busy    = 1'b1;
            calc_en = 1'b1;
            if (count == 5'd31)
               state_next = FIX;
         end
         FIX: begin
            busy       = 1'b1;
            fix_en     = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers: operand latch, iteration, result write and the
   // one-cycle done/div_by_zero pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= 5'd0;
         op_q   <= 2'b00;
         a_q    <= 32'd0;
         b_q    <= 32'd0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
         acc    <= 64'd0;
         hi_q   <= 32'd0;
         lo_q   <= 32'd0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         done_q <= fix_en;
         dbz_q  <= fix_en & op_q[1] & b_zero;
         if (latch_en) begin
            count  <= 5'd0;
            op_q   <= bus.op;
            a_q    <= rs_mag;
            b_q    <= rt_mag;
            sign_a <= neg_rs;
            sign_b <= neg_rt;
            b_zero <= (bus.rt_data == 32'd0);
            acc    <= {32'd0, bus.op[1] ? rs_mag : rt_mag};
         end else if (calc_en) begin
            count <= count + 5'd1;
            acc   <= acc_step;
         end
         if (fix_en) begin
            hi_q <= hi_res;
            lo_q <= lo_res;
         end else begin
            if (mthi_en)
               hi_q <= bus.rs_data;
            if (mtlo_en)
               lo_q <= bus.rs_data;
         end
      end
   end

   assign bus.busy        = busy;
   assign bus.done        = done_q;
   assign bus.div_by_zero = dbz_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// ---------------------------------------------------------------------------
// tb_md_unit : self-checking bench for md_unit. Expected HI/LO/div_by_zero
// values come from a behavioural model and are queued when an operation is
// started; a monitor pops and compares them whenever done pulses.
// ---------------------------------------------------------------------------
module tb_md_unit;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   md_unit_if bus();

   md_unit dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } result_t;

   result_t expQ[$];
   result_t monE;
   logic    prevDone = 1'b0;
   int      checks = 0;
   int      errors = 0;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Behavioural reference: 64-bit arithmetic sidesteps the 32-bit signed
   // overflow of 0x80000000 / -1.
   function automatic result_t model(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
      result_t     r;
      longint      sa, sb, q, m;
      logic [63:0] p;
      sa    = $signed(a);
      sb    = $signed(b);
      r.dbz = 1'b0;
      r.hi  = 32'd0;
      r.lo  = 32'd0;
      case (op)
         2'b00: begin
            p = sa * sb;
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         2'b01: begin
            p = {32'd0, a} * {32'd0, b};
            r.hi = p[63:32];
            r.lo = p[31:0];
         end
         default: begin
            if (b == 32'd0) begin
               r.hi  = a;
               r.lo  = 32'hFFFF_FFFF;
               r.dbz = 1'b1;
            end else if (op == 2'b10) begin
               q = sa / sb;
               m = sa % sb;
               r.lo = q[31:0];
               r.hi = m[31:0];
            end else begin
               r.lo = a / b;
               r.hi = a % b;
            end
         end
      endcase
      return r;
   endfunction

   // Drives one start at the current negedge (optionally with MTHI/MTLO in
   // the same cycle), queues the expected result and returns at the first
   // negedge after the start edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic mt);
      bus.start   = 1'b1;
      bus.op      = op;
      bus.rs_data = a;
      bus.rt_data = b;
      bus.hi_we   = mt;
      bus.lo_we   = mt;
      expQ.push_back(model(op, a, b));
      @(negedge clk);
      bus.start = 1'b0;
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
   endtask

   // Follows an operation from cycle 1 to done, optionally injecting a
   // second start and an MTHI at given cycles, and checks latency, busy
   // length and that HI/LO hold during the calculation.
   task automatic waitDone(input string tag, input int injStart, input int injHiwe);
      int          n = 1;
      int          busyCnt = 0;
      logic [31:0] hi0 = bus.hi;
      logic [31:0] lo0 = bus.lo;
      while (!bus.done && n < 100) begin
         if (bus.busy) busyCnt++;
         if (n == 33) begin
            checkOutput({tag, "_hold_hi"}, bus.hi, hi0);
            checkOutput({tag, "_hold_lo"}, bus.lo, lo0);
         end
         bus.start = (n == injStart);
         bus.hi_we = (n == injHiwe);
         if (n == injStart) begin
            bus.op      = 2'b11;
            bus.rs_data = 32'd99;
            bus.rt_data = 32'd0;
         end
         if (n == injHiwe) bus.rs_data = 32'hDEAD_BEEF;
         @(negedge clk);
         n++;
         bus.start = 1'b0;
         bus.hi_we = 1'b0;
      end
      checkOutput({tag, "_done_cycle"}, n, 34);
      checkOutput({tag, "_busy_cycles"}, busyCnt, 33);
      checkOutput({tag, "_busy_at_done"}, bus.busy, 1'b0);
   endtask

   // Scoreboard monitor: every done must match the oldest queued result.
   always @(negedge clk) begin
      if (!reset && bus.done) begin
         checkOutput("done_pulse", prevDone, 1'b0);
         if (expQ.size() == 0) begin
            checkOutput("unexpected_done", 1'b1, 1'b0);
         end else begin
            monE = expQ.pop_front();
            checkOutput("hi", bus.hi, monE.hi);
            checkOutput("lo", bus.lo, monE.lo);
            checkOutput("div_by_zero", bus.div_by_zero, monE.dbz);
         end
      end
      prevDone <= bus.done;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   logic [1:0]  dirOp [8] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b00};
   logic [31:0] dirA  [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7,
                              32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFB, 32'h8000_0000};
   logic [31:0] dirB  [8] = '{32'hFFFF_FFFF, 32'd7, 32'd2, 32'd2,
                              32'hFFFF_FFFF, 32'd0, 32'd0, 32'h8000_0000};

   initial begin
      logic [31:0] hiSave, loSave;
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      int          doneSeen;

      bus.start   = 1'b0;
      bus.op      = 2'b00;
      bus.rs_data = 32'd0;
      bus.rt_data = 32'd0;
      bus.hi_we   = 1'b0;
      bus.lo_we   = 1'b0;
      reset       = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("reset_busy", bus.busy, 1'b0);
      checkOutput("reset_done", bus.done, 1'b0);
      checkOutput("reset_dbz", bus.div_by_zero, 1'b0);
      checkOutput("reset_hi", bus.hi, 32'd0);
      checkOutput("reset_lo", bus.lo, 32'd0);
      reset = 1'b0;

      // Directed operations, back to back: each new start lands in the
      // cycle where the previous done is high.
      for (int i = 0; i < 8; i++) begin
         applyStimulus(dirOp[i], dirA[i], dirB[i], 1'b0);
         checkOutput($sformatf("dir%0d_busy", i), bus.busy, 1'b1);
         waitDone($sformatf("dir%0d", i), 0, 0);
      end
      @(negedge clk);

      // MTLO / MTHI while idle.
      hiSave      = bus.hi;
      bus.rs_data = 32'hA5A5_A5A5;
      bus.lo_we   = 1'b1;
      @(negedge clk);
      bus.lo_we = 1'b0;
      checkOutput("mtlo_lo", bus.lo, 32'hA5A5_A5A5);
      checkOutput("mtlo_hi", bus.hi, hiSave);
      bus.rs_data = 32'h5A5A_1234;
      bus.hi_we   = 1'b1;
      @(negedge clk);
      bus.hi_we = 1'b0;
      checkOutput("mthi_hi", bus.hi, 32'h5A5A_1234);
      checkOutput("mthi_lo", bus.lo, 32'hA5A5_A5A5);

      // start wins over a simultaneous MTHI/MTLO.
      applyStimulus(2'b01, 32'd2, 32'd3, 1'b1);
      checkOutput("start_wins_hi", bus.hi, 32'h5A5A_1234);
      checkOutput("start_wins_lo", bus.lo, 32'hA5A5_A5A5);
      waitDone("start_wins", 0, 0);

      // Second start at cycle 10 and MTHI at cycle 12 must be ignored.
      applyStimulus(2'b01, 32'd3, 32'd5, 1'b0);
      waitDone("mid_op", 10, 12);

      // Random operations, a quarter of them with a zero divisor.
      for (int i = 0; i < 8; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         if (i == 0) rb = 32'd0;
         applyStimulus(rop, ra, rb, 1'b0);
         waitDone($sformatf("rnd%0d", i), 0, 0);
      end
      @(negedge clk);

      // Reset in the middle of a calculation aborts it.
      bus.rs_data = 32'h1111_1111;
      bus.hi_we   = 1'b1;
      bus.lo_we   = 1'b1;
      @(negedge clk);
      bus.hi_we = 1'b0;
      bus.lo_we = 1'b0;
      checkOutput("pre_reset_hi", bus.hi, 32'h1111_1111);
      applyStimulus(2'b01, 32'd2, 32'd2, 1'b0);
      repeat (19) @(negedge clk);
      checkOutput("pre_reset_busy", bus.busy, 1'b1);
      #2 reset = 1'b1;
      #1;
      checkOutput("abort_busy", bus.busy, 1'b0);
      checkOutput("abort_hi", bus.hi, 32'd0);
      checkOutput("abort_lo", bus.lo, 32'd0);
      checkOutput("abort_done", bus.done, 1'b0);
      expQ.delete();
      @(negedge clk);
      reset    = 1'b0;
      doneSeen = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done) doneSeen++;
      end
      checkOutput("no_done_after_reset", doneSeen, 0);

      // First start right after reset release is accepted on the first edge.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(2'b11, 32'd7, 32'd2, 1'b0);
      waitDone("post_reset", 0, 0);
      @(negedge clk);
      checkOutput("queue_empty", expQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
